// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two requester ports plus the shared memory bus of the arbiter
interface mem_arbiter_if #(parameter int AW = 32, parameter int DW = 32);
  logic req0, req1, we0, we1, ack0, ack1;
  logic mem_read, mem_write, busy, gnt_id;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, mem_write_data, mem_read_data;
  modport slave (
    input req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    output ack0, ack1, rdata0, rdata1, mem_addr, mem_write_data, mem_read, mem_write, busy, gnt_id
  );
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_read_data,
    input ack0, ack1, rdata0, rdata1, mem_addr, mem_write_data, mem_read, mem_write, busy, gnt_id
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port arbiter serialising single reads/writes onto one memory bus
module mem_arbiter #(
  parameter int READ_WAIT = 3,
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic clk,
  input logic reset,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR} state_t;
  state_t state;
  logic [3:0] cnt;
  logic last_gnt, e0, e1, pick, nxt_we;
  logic [AW-1:0] nxt_addr;
  logic [DW-1:0] nxt_wdata;
  // a port whose ack is high this cycle is not eligible, which hands the next grant to the other port
  always_comb begin
    e0 = bus.req0 & ~bus.ack0;
    e1 = bus.req1 & ~bus.ack1;
    pick = (e0 & e1) ? ~last_gnt : e1;
    nxt_we = pick ? bus.we1 : bus.we0;
    nxt_addr = pick ? bus.addr1 : bus.addr0;
    nxt_wdata = pick ? bus.wdata1 : bus.wdata0;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      last_gnt <= 1'b1;
      bus.gnt_id <= 1'b0;
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      bus.mem_read <= 1'b0;
      bus.mem_write <= 1'b0;
      bus.busy <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_write_data <= '0;
      bus.rdata0 <= '0;
      bus.rdata1 <= '0;
    end else begin
      bus.ack0 <= 1'b0;
      bus.ack1 <= 1'b0;
      case (state)
        IDLE: if (e0 | e1) begin
          bus.mem_addr <= nxt_addr;
          bus.mem_write_data <= nxt_wdata;
          bus.gnt_id <= pick;
          last_gnt <= pick;
          bus.busy <= 1'b1;
          state <= nxt_we ? WR : RD;
          bus.mem_write <= nxt_we;
          bus.mem_read <= ~nxt_we;
          cnt <= nxt_we ? cnt : 4'(READ_WAIT);
        end
        RD: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            if (bus.gnt_id) bus.rdata1 <= bus.mem_read_data;
            else bus.rdata0 <= bus.mem_read_data;
            bus.ack0 <= ~bus.gnt_id;
            bus.ack1 <= bus.gnt_id;
            bus.mem_read <= 1'b0;
            bus.busy <= 1'b0;
            state <= IDLE;
          end
        end
        WR: begin
          bus.mem_write <= 1'b0;
          bus.ack0 <= ~bus.gnt_id;
          bus.ack1 <= bus.gnt_id;
          bus.busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  localparam int RW = 3, AW = 32, DW = 32;
  logic clk = 1'b0, reset = 1'b0, preload = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.AW(AW), .DW(DW)) bus();
  mem_arbiter #(.READ_WAIT(RW), .AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));
  logic [DW-1:0] mem [256];
  logic [DW-1:0] exp_mem [256];
  logic [DW-1:0] exp_rd [2];
  logic r [2];
  logic w [2];
  logic [AW-1:0] a [2];
  logic [DW-1:0] d [2];
  int unsigned seed;
  int tests = 0, fails = 0, last_m = 1, rd_cnt = 0, wr_cnt = 0;
  assign bus.req0 = r[0];
  assign bus.req1 = r[1];
  assign bus.we0 = w[0];
  assign bus.we1 = w[1];
  assign bus.addr0 = a[0];
  assign bus.addr1 = a[1];
  assign bus.wdata0 = d[0];
  assign bus.wdata1 = d[1];
  assign bus.mem_read_data = mem[bus.mem_addr[9:2]];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= (32'(i) * 32'h9E3779B1) ^ seed;
      mem[13] <= 32'hDEADBEEF;
    end else if (bus.mem_write) mem[bus.mem_addr[9:2]] <= bus.mem_write_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] x;
    x = '0;
    x[9:2] = 8'($urandom_range(0, 255));
    return x;
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_ack0"}, 64'(bus.ack0), 64'(0));
    chk({tag, "_ack1"}, 64'(bus.ack1), 64'(0));
    chk({tag, "_mem_read"}, 64'(bus.mem_read), 64'(0));
    chk({tag, "_mem_write"}, 64'(bus.mem_write), 64'(0));
    chk({tag, "_busy"}, 64'(bus.busy), 64'(0));
    chk({tag, "_gnt_id"}, 64'(bus.gnt_id), 64'(0));
    chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(0));
    chk({tag, "_mem_wdata"}, 64'(bus.mem_write_data), 64'(0));
    chk({tag, "_rdata0"}, 64'(bus.rdata0), 64'(0));
    chk({tag, "_rdata1"}, 64'(bus.rdata1), 64'(0));
  endtask

  task automatic wait_ack(input int start, output int n, output int who);
    n = start;
    who = -1;
    while (who < 0 && n < 40) begin
      @(negedge clk);
      n++;
      chk("ack_overlap", 64'(bus.ack0 & bus.ack1), 64'(0));
      chk("strobe_overlap", 64'(bus.mem_read & bus.mem_write), 64'(0));
      rd_cnt += int'(bus.mem_read);
      wr_cnt += int'(bus.mem_write);
      if (bus.ack0) who = 0;
      else if (bus.ack1) who = 1;
    end
  endtask

  task automatic single(input int p, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int n, who;
    r[p] = 1'b1; w[p] = we; a[p] = addr; d[p] = wd;
    rd_cnt = 0; wr_cnt = 0;
    @(negedge clk);
    rd_cnt += int'(bus.mem_read);
    wr_cnt += int'(bus.mem_write);
    chk("grant_busy", 64'(bus.busy), 64'(1));
    chk("grant_id", 64'(bus.gnt_id), 64'(p));
    chk("grant_addr", 64'(bus.mem_addr), 64'(addr));
    chk("grant_wdata", 64'(bus.mem_write_data), 64'(wd));
    a[p] = ~addr; d[p] = ~wd; w[p] = ~we;
    wait_ack(1, n, who);
    chk("ack_port", 64'(who), 64'(p));
    chk("latency", 64'(n), 64'(we ? 2 : RW + 1));
    chk("read_cycles", 64'(rd_cnt), 64'(we ? 0 : RW));
    chk("write_cycles", 64'(wr_cnt), 64'(we ? 1 : 0));
    chk("addr_held", 64'(bus.mem_addr), 64'(addr));
    chk("ack_cycle_idle", 64'(bus.busy), 64'(0));
    r[p] = 1'b0;
    if (we) begin
      exp_mem[addr[9:2]] = wd;
      chk("mem_written", 64'(mem[addr[9:2]]), 64'(wd));
    end else exp_rd[p] = exp_mem[addr[9:2]];
    chk("rdata0", 64'(bus.rdata0), 64'(exp_rd[0]));
    chk("rdata1", 64'(bus.rdata1), 64'(exp_rd[1]));
    last_m = p;
    @(negedge clk);
    chk("after_ack_idle", 64'(bus.busy), 64'(0));
  endtask

  task automatic both(input int nx);
    int n, who, ep;
    for (int k = 0; k < nx; k++) begin
      ep = 1 - last_m;
      wait_ack(0, n, who);
      chk("cont_winner", 64'(who), 64'(ep));
      chk("cont_gap", 64'(n), 64'(w[ep] ? 2 : RW + 1));
      chk("cont_addr", 64'(bus.mem_addr), 64'(a[ep]));
      if (w[ep]) begin
        exp_mem[a[ep][9:2]] = d[ep];
        chk("cont_mem", 64'(mem[a[ep][9:2]]), 64'(d[ep]));
      end else exp_rd[ep] = exp_mem[a[ep][9:2]];
      chk("cont_rdata0", 64'(bus.rdata0), 64'(exp_rd[0]));
      chk("cont_rdata1", 64'(bus.rdata1), 64'(exp_rd[1]));
      last_m = ep;
      w[ep] = 1'($urandom);
      a[ep] = rand_addr();
      d[ep] = $urandom;
    end
    r[0] = 1'b0; r[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic rst_pulse();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_m = 1;
    @(negedge clk);
  endtask

  initial begin
    int n, who;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    seed = $urandom;
    for (int i = 0; i < 256; i++) exp_mem[i] = (32'(i) * 32'h9E3779B1) ^ seed;
    exp_mem[13] = 32'hDEADBEEF;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int i = 0; i < 2; i++) begin r[i] = 1'b0; w[i] = 1'b0; a[i] = '0; d[i] = '0; end
    preload = 1'b1;
    @(negedge clk);
    preload = 1'b0;
    chk_reset("reset");
    reset = 1'b1;
    @(negedge clk);
    single(0, 1'b0, 32'h34, 32'h0);
    chk("read_deadbeef", 64'(bus.rdata0), 64'(32'hDEADBEEF));
    single(1, 1'b1, 32'hC8, 32'h12345678);
    chk("mem50", 64'(mem[50]), 64'(32'h12345678));
    chk("rdata1_untouched", 64'(bus.rdata1), 64'(0));
    rst_pulse();
    r[0] = 1'b1; w[0] = 1'b0; a[0] = 32'h0;
    r[1] = 1'b1; w[1] = 1'b0; a[1] = 32'h4;
    both(2);
    for (int i = 0; i < 2; i++) begin r[i] = 1'b1; w[i] = 1'($urandom); a[i] = rand_addr(); d[i] = $urandom; end
    both(10);
    ad = rand_addr();
    wd = $urandom;
    r[0] = 1'b1; w[0] = 1'b1; a[0] = ad; d[0] = wd;
    wait_ack(0, n, who);
    chk("held_ack", 64'(who), 64'(0));
    exp_mem[ad[9:2]] = wd;
    last_m = 0;
    @(negedge clk);
    chk("held_no_dup_grant", 64'(bus.busy), 64'(0));
    @(negedge clk);
    chk("held_regrant", 64'(bus.busy), 64'(1));
    chk("held_regrant_id", 64'(bus.gnt_id), 64'(0));
    r[0] = 1'b0;
    @(negedge clk);
    chk("held_reack", 64'(bus.ack0), 64'(1));
    @(negedge clk);
    chk("held_done", 64'(bus.busy), 64'(0));
    for (int k = 0; k < 20; k++) single(int'($urandom_range(0, 1)), 1'($urandom), rand_addr(), $urandom);
    r[0] = 1'b1; w[0] = 1'b0; a[0] = rand_addr();
    @(negedge clk);
    @(negedge clk);
    chk("midread_busy", 64'(bus.busy), 64'(1));
    reset = 1'b0;
    #1;
    chk_reset("midread");
    r[0] = 1'b0;
    @(negedge clk);
    chk("midread_no_ack0", 64'(bus.ack0), 64'(0));
    chk("midread_no_ack1", 64'(bus.ack1), 64'(0));
    reset = 1'b1;
    exp_rd[0] = '0; exp_rd[1] = '0;
    last_m = 1;
    @(negedge clk);
    chk("postreset_idle", 64'(bus.busy), 64'(0));
    single(0, 1'b0, rand_addr(), $urandom);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter READ_WAIT, 3: mem_read hold cycles per read; legal range 1..15.
REQ-002 Parameter AW, 32: address width.
REQ-003 Parameter DW, 32: data width.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 reset  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-006 req0, req1  input  1 each  port request, held until ack.
REQ-007 we0, we1  input  1 each  1 = write, 0 = read.
REQ-008 addr0, addr1  input  AW each  byte address.
REQ-009 wdata0, wdata1  input  DW each  write data.
REQ-010 ack0, ack1  output  1 each  one-cycle completion pulse.
REQ-011 rdata0, rdata1  output  DW each  registered read data for the port.
REQ-012 mem_addr  output  AW  registered memory address.
REQ-013 mem_write_data  output  DW  registered memory write data.
REQ-014 mem_read, mem_write  output  1 each  registered memory strobes.
REQ-015 mem_read_data  input  DW  memory read data; combinational, valid within READ_WAIT cycles of mem_read rising.
REQ-016 busy  output  1  high when state is not IDLE.
REQ-017 gnt_id  output  1  port owning the current or last transfer.

Function
REQ-018 FSM states SHALL be IDLE, RD and WR; one transfer at a time; no pipelining.
REQ-019 In IDLE, a port SHALL be eligible when its req=1 and its ack=0 that cycle.
REQ-020 With one eligible port, IDLE SHALL grant it; with both eligible, it SHALL grant the port not equal to last_gnt (round-robin).
REQ-021 On grant edge: latch addr to mem_addr, wdata to mem_write_data, set gnt_id and last_gnt; go to RD (we=0) or WR (we=1).
REQ-022 On entry to RD: mem_read=1 and wait counter=READ_WAIT.
REQ-023 In RD, each edge SHALL decrement the counter.
REQ-024 On the RD edge with counter==1: capture mem_read_data into the granted rdata; set that ack for one cycle; clear mem_read; go to IDLE.
REQ-025 mem_read SHALL be high for exactly READ_WAIT cycles per read.
REQ-026 Read latency: ack high in cycle READ_WAIT+1 after the grant edge.
REQ-027 On entry to WR: mem_write=1 for exactly one cycle.
REQ-028 On the next edge: clear mem_write, set the granted ack for one cycle, go to IDLE.
REQ-029 Write latency: ack high in cycle 2 after the grant edge.
REQ-030 ack0 and ack1 SHALL never be high together.
REQ-031 mem_read and mem_write SHALL never be high together.
REQ-032 rdata of a port SHALL change only on that port's read completion; writes leave rdata unchanged.
REQ-033 A requester SHALL drop req, or present a new request, after its ack cycle.
REQ-034 REQ-019 blocks the acked port for that cycle, so the other waiting port wins the next grant.
REQ-035 req changes while busy=1 SHALL be ignored; latched address and data SHALL not change mid-transfer.
REQ-036 Starvation bound: a continuously requesting port SHALL be granted within one other transfer.

Reset
REQ-037 While reset=0, asynchronously: state=IDLE, counter=0, last_gnt=1, gnt_id=0, and all of the following cleared to 0: ack0, ack1, mem_read, mem_write, busy, mem_addr, mem_write_data, rdata0, rdata1.
REQ-038 Reset mid-transfer SHALL abort with no ack.
REQ-039 After reset release, the first grant on a tie SHALL go to port 0.

Verification
REQ-040 Single read: READ_WAIT=3; mem[0x34>>2]=0xDEADBEEF; req0=1, we0=0, addr0=0x34 -> mem_read high 3 cycles, mem_addr=0x34, ack0 pulse in cycle 4, rdata0=0xDEADBEEF.
REQ-041 Single write: req1=1, we1=1, addr1=0xC8, wdata1=0x12345678 -> mem_write high 1 cycle, ack1 in cycle 2, mem[50]=0x12345678, rdata1 unchanged.
REQ-042 Simultaneous requests after reset: port 0 read 0x0, port 1 read 0x4, both held -> port 0 acked first, port 1 granted next, ack1 in cycle 8; no overlapping acks.
REQ-043 Continuous contention: req0 and req1 held high for 10 transfers -> grants alternate 0,1,0,1...; no port waits more than one transfer.
REQ-044 Reset mid-read: reset=0 while counter=2 -> all outputs 0 immediately, no ack; after release, a new req0 read completes normally.
REQ-045 Held req after ack: req0 stays high one cycle past ack0 with req1=0 -> no duplicate grant in the ack cycle; a grant follows only if req0 is still high in IDLE.
